// File: rtl/midi_fifo_ctrl.sv
// rtl/midi_fifo_ctrl.sv - ring-buffer controller turning a 512x8 dual-port RAM into a byte FIFO
//
// Ports:
//   clk, rst_n                    single clock (also RAM wclk/rclk), synchronous active-low reset
//   flush                         synchronous clear of pointers and output stage (keeps overflow)
//   in_data/in_valid/in_ready     producer side; in_ready low when RAM holds DEPTH bytes
//   out_data/out_valid/out_ready  consumer side; first-word-fall-through output register
//   ram_wdata/ram_waddr/ram_we    RAM write port
//   ram_raddr/ram_re/ram_rdata    RAM read port; rdata valid the cycle after ram_re
//   level                         bytes in RAM not yet fetched (wr_ptr - rd_ptr)
//   overflow/ovf_clr              sticky dropped-push flag and its clear
module midi_fifo_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr
);

    // Level value meaning "every RAM entry holds an unfetched byte".
    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t          state;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            clear;
    logic            has_data;

    // Reset and flush share the same pointer/output-stage clear path.
    assign clear    = ~rst_n | flush;
    assign level    = wr_ptr - rd_ptr;
    assign has_data = (level != '0);
    assign in_ready = (level != FULL_LEVEL);

    assign ram_wdata = in_data;
    assign ram_waddr = wr_ptr[ADDR_W-1:0];
    assign ram_raddr = rd_ptr[ADDR_W-1:0];
    assign ram_we    = in_valid & in_ready & ~clear;

    // Fetch strobe: refill the output register whenever it is (or is about
    // to become) empty and the RAM has a committed byte.
    always_comb begin
        ram_re = 1'b0;
        if (!clear) begin
            case (state)
                S_EMPTY: ram_re = has_data;
                S_VALID: ram_re = out_ready & has_data;
                default: ram_re = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (state)
                S_EMPTY: begin
                    if (ram_re) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    out_data  <= ram_rdata;
                    out_valid <= 1'b1;
                    state     <= S_VALID;
                end
                S_VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ram_re ? S_FETCH : S_EMPTY;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_EMPTY;
                end
            endcase
        end
    end

    // Sticky overflow: a set event beats a same-cycle clear; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid & ~in_ready) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_midi_fifo_ctrl.sv
// tb/tb_midi_fifo_ctrl.sv - self-checking bench for midi_fifo_ctrl with a behavioural 512x8 RAM
module tb_midi_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, out_ready, ovf_clr;
    logic [7:0] in_data;
    logic       in_ready, out_valid, ram_we, ram_re, overflow;
    logic [7:0] out_data, ram_wdata, ram_rdata;
    logic [8:0] ram_waddr, ram_raddr;
    logic [9:0] level;

    logic [7:0] mem [512];
    logic [7:0] sb [$];
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    midi_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_wdata(ram_wdata), .ram_waddr(ram_waddr), .ram_we(ram_we),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: push on accepted input, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back(in_data);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got %0h expected nothing", out_data);
                end else begin
                    chk("out_order", {24'd0, out_data}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic rst_n, flush, in_valid;
        logic [7:0] in_data;
        logic out_ready, ovf_clr;
        logic e_in_ready, e_out_valid;
        logic [7:0] e_out_data;
        logic [9:0] e_level;
        logic e_we;
        logic [8:0] e_waddr;
        logic e_re;
        logic [8:0] e_raddr;
        logic e_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_data = 0; out_ready = 0; ovf_clr = 0;
    endtask

    task automatic push_n(input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            in_data  = rnd ? 8'($urandom) : 8'(base + i);
            tick();
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        out_ready = 1;
        while (sb.size() != 0 && cnt < 3000) begin
            tick();
            cnt++;
        end
        out_ready = 0;
        chk("drain_done", sb.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        int wbase;
        int cnt;
        rst_n = 0;
        idle_inputs();
        tick();
        tick();

        // rst_n flush iv data ordy oc | ir ov odata lvl we waddr re raddr ovf
        vecs[0] = '{0, 0, 1, 8'h55, 0, 0, 1, 0, 8'h00, 10'd0, 0, 9'd0, 0, 9'd0, 0};
        vecs[1] = '{1, 0, 1, 8'h90, 0, 0, 1, 0, 8'h00, 10'd0, 1, 9'd0, 0, 9'd0, 0};
        vecs[2] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 10'd1, 0, 9'd1, 1, 9'd0, 0};
        vecs[3] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 10'd0, 0, 9'd1, 0, 9'd1, 0};
        vecs[4] = '{1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h90, 10'd0, 0, 9'd1, 0, 9'd1, 0};
        vecs[5] = '{1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h90, 10'd0, 0, 9'd1, 0, 9'd1, 0};
        vecs[6] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h90, 10'd0, 0, 9'd1, 0, 9'd1, 0};

        for (int i = 0; i < 7; i++) begin
            rst_n = vecs[i].rst_n; flush = vecs[i].flush; in_valid = vecs[i].in_valid;
            in_data = vecs[i].in_data; out_ready = vecs[i].out_ready; ovf_clr = vecs[i].ovf_clr;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_out_data);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
            chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
            chk($sformatf("v%0d_waddr", i), ram_waddr, vecs[i].e_waddr);
            chk($sformatf("v%0d_ram_re", i), ram_re, vecs[i].e_re);
            chk($sformatf("v%0d_raddr", i), ram_raddr, vecs[i].e_raddr);
            chk($sformatf("v%0d_overflow", i), overflow, vecs[i].e_ovf);
            tick();
        end
        idle_inputs();
        drain();

        // Fill to full: one byte sits in the output register, 512 in RAM.
        rst_n = 0;
        tick();
        rst_n = 1;
        push_n(513, 1, 0);
        chk("full_sb_size", sb.size(), 513);
        chk("full_level", level, 512);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_no_ovf", overflow, 0);
        in_valid = 1; in_data = 8'hEE;
        @(negedge clk);
        chk("drop_we", ram_we, 0);
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 512);
        ovf_clr = 1;
        tick();
        chk("ovf_set_wins", overflow, 1);
        in_valid = 0; ovf_clr = 0;
        drain();
        chk("drain_level", level, 0);
        chk("ovf_held", overflow, 1);

        // Wrap-around: three 300-byte fill/drain rounds.
        wbase = 513;
        for (int r = 0; r < 3; r++) begin
            push_n(300, 0, 1);
            wbase += 300;
            chk($sformatf("wrap%0d_level", r), level, 299);
            chk($sformatf("wrap%0d_waddr", r), ram_waddr, wbase % 512);
            drain();
            chk($sformatf("wrap%0d_empty", r), level, 0);
        end

        // Balanced push/pop at level 5.
        push_n(6, 8'h40, 0);
        chk("bal_start", level, 5);
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid = out_valid;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk($sformatf("bal_level%0d", i), (level >= 4 && level <= 6), 1);
            tick();
        end
        in_valid = 0;
        drain();

        // Flush while in FETCH with level 10.
        push_n(12, 8'h60, 0);
        chk("pre_flush_level", level, 11);
        out_ready = 1;
        tick();
        out_ready = 0;
        flush = 1; in_valid = 1; in_data = 8'h33;
        @(negedge clk);
        chk("fetch_out_valid", out_valid, 0);
        chk("fetch_level", level, 10);
        chk("flush_re", ram_re, 0);
        chk("flush_we", ram_we, 0);
        tick();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("post_flush_level", level, 0);
        chk("post_flush_valid", out_valid, 0);
        chk("post_flush_data", out_data, 0);
        chk("post_flush_ovf", overflow, 1);
        tick();
        chk("inflight_discard", out_valid, 0);
        push_n(1, 8'hA5, 0);
        drain();

        // Hold in VALID with out_ready low.
        push_n(3, 8'h11, 0);
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid%0d", i), out_valid, 1);
            chk($sformatf("hold_data%0d", i), out_data, 8'h11);
            chk($sformatf("hold_re%0d", i), ram_re, 0);
            chk($sformatf("hold_raddr%0d", i), ram_raddr, 2);
            tick();
        end
        drain();

        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_cleared", overflow, 0);

        rst_n = 0;
        tick();
        chk("final_reset_level", level, 0);
        chk("final_reset_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
